ifetch_unit: RTL and testbench

- Instruction fetch initiator for the instruction memory.
- Owns the program counter and drives a word-aligned address to the combinational-read instruction memory. Captures the returned instruction word each cycle and buffers {pc, instr} pairs in a small FIFO.
- Presents the buffered pairs to decode over a valid/ready handshake.
- Handles branch/jump redirects and halt requests from the core.

---
 rtl/ifetch_pkg.sv | 18 +
 rtl/ifetch_fifo.sv | 62 ++++++
 rtl/ifetch_unit.sv | 105 ++++++++++
 tb/tb_ifetch_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch unit.
// Holds the state enum, FIFO entry struct and instruction size.
package ifetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } ifetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO of fetch_entry_t; flush beats push and pop.
// Ports: clk, rst_n, i_push/i_pop/i_flush, i_data, o_full, o_empty, o_head.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output logic         o_full,
  output logic         o_empty,
  output fetch_entry_t o_head
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t   r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr;
  logic [AW-1:0]  r_rd;
  logic [CW-1:0]  r_cnt;
  logic           w_push;
  logic           w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CW'(FIFO_DEPTH));
  assign o_head  = r_mem[r_rd];
  assign w_pop   = i_pop && !o_empty;
  // A push into a full FIFO is legal only alongside a pop.
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push && !i_flush)
      r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push)
        r_wr <= r_wr + 1'b1;
      if (w_pop)
        r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push)
        r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the PC, prefetches into a FIFO, serves decode.
// Ports: clk, rst_n, imem_addr/imem_data, redirect_valid/redirect_pc,
// halt_req, out_valid/out_ready/out_instr/out_pc, halted, fetch_fault.
// Optional: IFETCH_MISALIGN_TRAP_EN traps misaligned redirects into FAULT.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic        fetch_fault
);

  logic [31:0]   r_pc;
  ifetch_state_e r_state;
  logic          r_halted;
  logic          r_fault;
  fetch_entry_t  r_last;

  logic          w_full;
  logic          w_empty;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;
  logic          w_pop;
  logic          w_fetch;
  logic          w_misalign;

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign w_misalign = (redirect_pc[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  assign imem_addr   = r_pc;
  assign out_valid   = !w_empty;
  assign w_pop       = out_valid && out_ready;
  assign w_fetch     = (r_state == RUN) && !redirect_valid
                    && (!w_full || w_pop);
  assign w_push_data = '{pc: r_pc, instr: imem_data};

  // Outputs hold the last presented entry while the FIFO is empty.
  assign out_pc      = out_valid ? w_head.pc    : r_last.pc;
  assign out_instr   = out_valid ? w_head.instr : r_last.instr;
  assign halted      = r_halted;
  assign fetch_fault = r_fault;

  ifetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_fetch),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  (w_push_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_state  <= RUN;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
      r_last   <= '0;
    end else begin
      if (out_valid)
        r_last <= w_head;
      if (redirect_valid) begin
        if (w_misalign) begin
          r_state  <= FAULT;
          r_halted <= 1'b1;
          r_fault  <= 1'b1;
        end else begin
          r_pc     <= redirect_pc & ~32'h3;
          r_state  <= RUN;
          r_halted <= 1'b0;
          r_fault  <= 1'b0;
        end
      end else begin
        if (w_fetch)
          r_pc <= r_pc + 32'(INSTR_BYTES);
        if (r_state == RUN && halt_req) begin
          r_state  <= HALT;
          r_halted <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit.
// Honors IFETCH_MISALIGN_TRAP_EN for the misaligned-redirect step.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt_req = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    case (a[31:2])
      30'd0:   memw = 32'h2008_0001;
      30'd1:   memw = 32'h2009_0002;
      30'd2:   memw = 32'h0109_5020;
      30'd3:   memw = 32'hAC0A_0000;
      default: memw = {16'hC0DE, a[15:0]};
    endcase
  endfunction

  assign imem_data = memw(imem_addr);

  ifetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted),
    .fetch_fault    (fetch_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_instr"}, out_instr, memw(pc));
  endtask

  initial begin
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    #1 rst_n = 1'b1;

    // Stream from reset with ready held high.
    step();
    for (int k = 0; k < 4; k++) begin
      chk_out("stream", 32'(4 * k));
      step();
    end

    // Async reset between edges, then back-pressure.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_addr", imem_addr, 32'd0);
    chk("arst_pc", out_pc, 32'd0);
    out_ready = 1'b0;
    #1 rst_n = 1'b1;
    repeat (5) step();
    chk_out("bp_hold", 32'h0);
    chk("bp_addr", imem_addr, 32'h8);
    out_ready = 1'b1;
    step();
    chk_out("bp_d0", 32'h4);
    step();
    chk_out("bp_d1", 32'h8);
    step();
    chk_out("bp_d2", 32'hC);
    chk("bp_addr2", imem_addr, 32'h14);

    // Redirect with two entries pending.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("rd_valid", 32'(out_valid), 32'd0);
    chk("rd_addr", imem_addr, 32'h40);
    chk("rd_hold", out_pc, 32'hC);
    step();
    chk_out("rd_t0", 32'h40);
    step();
    chk_out("rd_t1", 32'h44);

    // Halt: drain buffered entries, freeze fetch.
    out_ready = 1'b0;
    halt_req  = 1'b1;
    step();
    halt_req = 1'b0;
    chk("hlt_halted", 32'(halted), 32'd1);
    chk_out("hlt_head", 32'h44);
    chk("hlt_addr", imem_addr, 32'h4C);
    out_ready = 1'b1;
    step();
    chk_out("hlt_d0", 32'h48);
    step();
    chk("hlt_empty", 32'(out_valid), 32'd0);
    chk("hlt_hold", out_pc, 32'h48);
    chk("hlt_addr2", imem_addr, 32'h4C);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    chk("hlt_still", 32'(halted), 32'd1);
    chk("hlt_nofetch", 32'(out_valid), 32'd0);
    chk("hlt_addr3", imem_addr, 32'h4C);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    step();
    redirect_valid = 1'b0;
    chk("res_halted", 32'(halted), 32'd0);
    chk("res_addr", imem_addr, 32'h0);
    step();
    chk_out("res_t0", 32'h0);

    // Misaligned redirect.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    step();
    redirect_valid = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk("mis_fault", 32'(fetch_fault), 32'd1);
    chk("mis_halted", 32'(halted), 32'd1);
    chk("mis_valid", 32'(out_valid), 32'd0);
    step();
    step();
    chk("mis_valid2", 32'(out_valid), 32'd0);
    chk("mis_fault2", 32'(fetch_fault), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h44;
    step();
    redirect_valid = 1'b0;
    chk("mis_clr", 32'(fetch_fault), 32'd0);
    chk("mis_run", 32'(halted), 32'd0);
    step();
    chk_out("mis_t0", 32'h44);
`else
    chk("mis_addr", imem_addr, 32'h40);
    chk("mis_fault", 32'(fetch_fault), 32'd0);
    chk("mis_halted", 32'(halted), 32'd0);
    step();
    chk_out("mis_t0", 32'h40);
`endif

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    chk_out("wrap_top", 32'hFFFF_FFFC);
    step();
    chk_out("wrap_zero", 32'h0);

    // Async reset mid-stream, restart at RESET_PC.
    #2 rst_n = 1'b0;
    #1;
    chk("arst2_valid", 32'(out_valid), 32'd0);
    chk("arst2_addr", imem_addr, 32'd0);
    #1 rst_n = 1'b1;
    step();
    chk_out("arst2_t0", 32'h0);
    step();
    chk_out("arst2_t1", 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
